icache_nwa: RTL

Parametrised N-way set-associative, read-only instruction cache between the picorv32 native memory port and the `imem` word-fetch port. It generalises the direct-mapped `icache_1wa` with configurable associativity and per-set round-robin replacement. It also adds multi-word line refill with memory stalls, a flush request, and hit/miss counters. With `NUM_WAYS=1` its behaviour equals a direct-mapped cache.

---
 rtl/icache_nwa.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/icache_nwa.sv
`default_nettype none
// ============================================================================
//  Module   : icache_nwa
//  Purpose  : N-way set-associative, read-only instruction cache sitting
//             between a processor fetch port and a word-read memory port.
//             Multi-word line refill (word 0 first), per-set round-robin
//             replacement, deferred flush, and hit/miss counters.
//  Ports    : clk, resetn (sync, active low)
//             proc_valid/proc_addr  -> fetch request in
//             proc_ready/proc_rdata <- one-cycle completion pulse + word
//             mem_req_valid/mem_req_addr -> refill word request out
//             mem_req_ready/mem_req_rdata <- memory accept + data
//             flush -> invalidate all lines (deferred while busy)
//             hit_count/miss_count <- completed-request counters
//  Revision : 1.0 - initial release
// ============================================================================
module icache_nwa #(
    parameter int CACHE_SIZE = 1024,
    parameter int NUM_WAYS   = 2,
    parameter int NUM_BLOCKS = 2,
    parameter int BLOCK_SIZE = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        proc_valid,
    output logic        proc_ready,
    input  logic [31:0] proc_addr,
    output logic [31:0] proc_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic [31:0] mem_req_rdata,
    input  logic        flush,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int LINE  = NUM_BLOCKS * BLOCK_SIZE;
    localparam int SETS  = CACHE_SIZE / (LINE * NUM_WAYS);
    localparam int OFF_W = $clog2(LINE);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - OFF_W;
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int BLK_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NUM_WAYS - 1);
    localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NUM_BLOCKS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_REFILL  = 3'd2,
        S_RESPOND = 3'd3,
        S_FLUSH   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic [BLK_W-1:0]  k_q, k_d;
    logic              proc_ready_q, proc_ready_d;
    logic [31:0]       proc_rdata_q, proc_rdata_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic [31:0]       mem_req_addr_q, mem_req_addr_d;
    logic [31:0]       hit_count_q, hit_count_d;
    logic [31:0]       miss_count_q, miss_count_d;
    logic              flush_pend_q, flush_pend_d;

    // Line storage
    logic [NUM_WAYS-1:0] valid_q [SETS];
    logic [WAY_W-1:0]    rr_q    [SETS];
    logic [TAG_W-1:0]    tag_q   [SETS][NUM_WAYS];
    logic [31:0]         data_q  [SETS][NUM_WAYS][NUM_BLOCKS];

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [BLK_W-1:0]  w_blk;
    logic [31:0]       w_line_base;
    logic [BLK_W-1:0]  w_k_next;
    logic              w_hit;
    logic [WAY_W-1:0]  w_hit_way;
    logic [WAY_W-1:0]  w_victim;
    logic              w_victim_from_rr;
    logic [31:0]       w_hit_word;
    logic              w_valid_clr, w_valid_set, w_rr_adv, w_flush_all, w_fill_we;

    assign w_idx       = addr_q[OFF_W +: IDX_W];
    assign w_tag       = addr_q[31 -: TAG_W];
    assign w_line_base = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
    assign w_k_next    = k_q + 1'b1;

    // With single-word lines there is no word-select field in the address.
    generate
        if (NUM_BLOCKS > 1) begin : g_blk_sel
            assign w_blk = addr_q[2 +: BLK_W];
        end else begin : g_blk_single
            assign w_blk = '0;
        end
    endgenerate

    // Parallel tag compare and victim choice for the set addressed by addr_q.
    always_comb begin
        w_hit            = 1'b0;
        w_hit_way        = '0;
        w_victim         = rr_q[w_idx];
        w_victim_from_rr = 1'b1;
        // Scan downward so the lowest-index invalid way is the one that sticks.
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w_idx][w]) begin
                w_victim         = WAY_W'(w);
                w_victim_from_rr = 1'b0;
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[w_idx][w] && (tag_q[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    assign w_hit_word = data_q[w_idx][w_hit_way][w_blk];

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        victim_d        = victim_q;
        k_d             = k_q;
        proc_ready_d    = 1'b0;
        proc_rdata_d    = proc_rdata_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        hit_count_d     = hit_count_q;
        miss_count_d    = miss_count_q;
        flush_pend_d    = flush_pend_q;
        w_valid_clr     = 1'b0;
        w_valid_set     = 1'b0;
        w_rr_adv        = 1'b0;
        w_flush_all     = 1'b0;
        w_fill_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A flush (new or deferred) beats a simultaneous fetch.
                if (flush || flush_pend_q) begin
                    flush_pend_d = 1'b0;
                    state_d      = S_FLUSH;
                end else if (proc_valid) begin
                    addr_d  = proc_addr;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                flush_pend_d = flush_pend_q | flush;
                if (w_hit) begin
                    proc_rdata_d = w_hit_word;
                    proc_ready_d = 1'b1;
                    hit_count_d  = hit_count_q + 32'd1;
                    state_d      = S_RESPOND;
                end else begin
                    // Victim is invalidated up front so a half-written line
                    // can never be seen as valid.
                    victim_d        = w_victim;
                    w_valid_clr     = 1'b1;
                    w_rr_adv        = w_victim_from_rr;
                    k_d             = '0;
                    mem_req_valid_d = 1'b1;
                    mem_req_addr_d  = w_line_base;
                    state_d         = S_REFILL;
                end
            end
            S_REFILL: begin
                flush_pend_d = flush_pend_q | flush;
                if (mem_req_ready) begin
                    w_fill_we = 1'b1;
                    if (k_q == w_blk) begin
                        proc_rdata_d = mem_req_rdata;
                    end
                    if (k_q == LAST_BLK) begin
                        w_valid_set     = 1'b1;
                        mem_req_valid_d = 1'b0;
                        proc_ready_d    = 1'b1;
                        miss_count_d    = miss_count_q + 32'd1;
                        state_d         = S_RESPOND;
                    end else begin
                        k_d            = w_k_next;
                        mem_req_addr_d = w_line_base | {{(30 - BLK_W){1'b0}}, w_k_next, 2'b00};
                    end
                end
            end
            S_RESPOND: begin
                flush_pend_d = flush_pend_q | flush;
                state_d      = S_IDLE;
            end
            S_FLUSH: begin
                w_flush_all = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            victim_q        <= '0;
            k_q             <= '0;
            proc_ready_q    <= 1'b0;
            proc_rdata_q    <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            hit_count_q     <= '0;
            miss_count_q    <= '0;
            flush_pend_q    <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            victim_q        <= victim_d;
            k_q             <= k_d;
            proc_ready_q    <= proc_ready_d;
            proc_rdata_q    <= proc_rdata_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            hit_count_q     <= hit_count_d;
            miss_count_q    <= miss_count_d;
            flush_pend_q    <= flush_pend_d;
            if (w_flush_all) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                    rr_q[s]    <= '0;
                end
            end else begin
                if (w_valid_clr) begin
                    valid_q[w_idx][w_victim] <= 1'b0;
                end
                if (w_valid_set) begin
                    valid_q[w_idx][victim_q] <= 1'b1;
                end
                if (w_rr_adv) begin
                    rr_q[w_idx] <= (rr_q[w_idx] == LAST_WAY) ? '0 : rr_q[w_idx] + 1'b1;
                end
            end
        end
    end

    // Tag and data arrays need no reset: the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            data_q[w_idx][victim_q][k_q] <= mem_req_rdata;
        end
        if (w_valid_set) begin
            tag_q[w_idx][victim_q] <= w_tag;
        end
    end

    assign proc_ready    = proc_ready_q;
    assign proc_rdata    = proc_rdata_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign hit_count     = hit_count_q;
    assign miss_count    = miss_count_q;

endmodule
`default_nettype wire
